// File: rtl/syn_result_drain.sv
// syn_result_drain: buffers D tiles from the GEMM core, requantises every
// element (round half up, arithmetic shift, saturate to P bits) and streams
// each tile out one row per beat, flagging the last row of the tile.
module syn_result_drain #(
   parameter int M     = 2,
   parameter int N     = 2,
   parameter int P     = 8,
   parameter int DEPTH = 2,
   parameter int SW    = $clog2(4*P)
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [M-1:0][N-1:0][4*P-1:0]              D_i,
   input  logic [SW-1:0]                             shift_i,
   input  logic                                      valid_i,
   output logic                                      ready_o,
   output logic [N-1:0][P-1:0]                       row_o,
   output logic [((M > 1) ? $clog2(M) : 1)-1:0]      row_idx_o,
   output logic                                      last_o,
   output logic                                      valid_o,
   input  logic                                      ready_i,
   output logic [15:0]                               sat_cnt_o
);

   localparam int W   = 4*P;
   localparam int RW  = (M > 1) ? $clog2(M) : 1;
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int NSW = $clog2(N + 1);

   localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
   localparam logic [RW-1:0]       LAST_ROW = RW'(M - 1);
   localparam logic [PW-1:0]       LAST_PTR = PW'(DEPTH - 1);
   localparam logic [SW-1:0]       S_MAX    = SW'(W - 1);
   localparam logic signed [W:0]   SAT_HI   = (W+1)'(2**(P-1) - 1);
   localparam logic signed [W:0]   SAT_LO   = (W+1)'(-(2**(P-1)));

   typedef enum logic [1:0] {ST_EMPTY, ST_STREAM, ST_FULL} state_e;

   // Requantise one element; bit P of the result flags saturation.
   function automatic logic [P:0] requant(input logic [W-1:0] x, input logic [SW-1:0] sh);
      logic [SW-1:0]   s;
      logic signed [W:0] ext;
      logic signed [W:0] rnd;
      logic signed [W:0] y;
      logic [P:0]      res;
      s   = (sh > S_MAX) ? S_MAX : sh;
      ext = $signed({x[W-1], x});
      if (s == {SW{1'b0}}) begin
         rnd = {(W+1){1'b0}};
      end else begin
         rnd = $signed({{W{1'b0}}, 1'b1} << (s - SW'(1)));
      end
      y = (ext + rnd) >>> s;
      if (y > SAT_HI) begin
         res = {1'b1, SAT_HI[P-1:0]};
      end else if (y < SAT_LO) begin
         res = {1'b1, SAT_LO[P-1:0]};
      end else begin
         res = {1'b0, y[P-1:0]};
      end
      return res;
   endfunction

   logic [M-1:0][N-1:0][W-1:0] tile_q [DEPTH];
   logic [SW-1:0]              shift_q [DEPTH];

   state_e          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [RW-1:0]   row_q, row_d;
   logic [15:0]     sat_cnt_q, sat_cnt_d;

   logic            push_s;
   logic            beat_s;
   logic            pop_s;
   logic [P:0]      rq_s [N];
   logic [N-1:0][P-1:0] row_s;
   logic [NSW-1:0]  nsat_s;
   logic [16:0]     sat_sum_s;

   // Handshake and output view of the head tile's current row.
   always_comb begin
      ready_o   = !rst_i && (count_q < DEPTH_C);
      valid_o   = !rst_i && (state_q != ST_EMPTY);
      push_s    = valid_i && ready_o;
      beat_s    = valid_o && ready_i;
      pop_s     = beat_s && (row_q == LAST_ROW);
      nsat_s    = {NSW{1'b0}};
      row_s     = {(N*P){1'b0}};
      for (int n = 0; n < N; n++) begin
         rq_s[n]  = requant(tile_q[rd_ptr_q][row_q][n], shift_q[rd_ptr_q]);
         row_s[n] = rq_s[n][P-1:0];
         nsat_s   = nsat_s + NSW'(rq_s[n][P]);
      end
      if (rst_i) begin
         row_o     = {(N*P){1'b0}};
         row_idx_o = {RW{1'b0}};
         last_o    = 1'b0;
      end else begin
         row_o     = row_s;
         row_idx_o = row_q;
         last_o    = valid_o && (row_q == LAST_ROW);
      end
      sat_cnt_o = sat_cnt_q;
   end

   // Next-state for pointers, fill level, row counter, saturation count and FSM.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      row_d     = row_q;
      sat_cnt_d = sat_cnt_q;
      state_d   = state_q;
      sat_sum_s = {1'b0, sat_cnt_q} + 17'(nsat_s);

      if (push_s) begin
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
         row_d    = {RW{1'b0}};
      end else if (beat_s) begin
         row_d    = row_q + RW'(1);
      end else begin
         row_d    = row_q;
      end

      if (beat_s) begin
         sat_cnt_d = sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
      end else begin
         sat_cnt_d = sat_cnt_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         ST_EMPTY: begin
            if (push_s) begin
               state_d = (count_d == DEPTH_C) ? ST_FULL : ST_STREAM;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_STREAM, ST_FULL: begin
            if (count_d == {CW{1'b0}}) begin
               state_d = ST_EMPTY;
            end else if (count_d == DEPTH_C) begin
               state_d = ST_FULL;
            end else begin
               state_d = ST_STREAM;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_EMPTY;
         wr_ptr_q  <= {PW{1'b0}};
         rd_ptr_q  <= {PW{1'b0}};
         count_q   <= {CW{1'b0}};
         row_q     <= {RW{1'b0}};
         sat_cnt_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         row_q     <= row_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   // Tile storage; data is only meaningful while counted, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         tile_q[wr_ptr_q]  <= D_i;
         shift_q[wr_ptr_q] <= shift_i;
      end
   end

endmodule

// File: tb/tb_syn_result_drain.sv
// Self-checking bench for syn_result_drain (M=N=2, P=8, DEPTH=2): directed
// scenarios plus randomized traffic, compared against a queue-based model.
module tb_syn_result_drain;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [1:0][1:0][31:0] e;
      logic [4:0]            sh;
   } tile_t;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [1:0][1:0][31:0] D_i;
   logic [4:0]            shift_i;
   logic                  valid_i;
   logic                  ready_o;
   logic [1:0][7:0]       row_o;
   logic [0:0]            row_idx_o;
   logic                  last_o;
   logic                  valid_o;
   logic                  ready_i;
   logic [15:0]           sat_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   tile_t   mq[$];
   int      mr   = 0;
   longint  msat = 0;

   syn_result_drain #(.M(2), .N(2), .P(8), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .D_i(D_i), .shift_i(shift_i),
      .valid_i(valid_i), .ready_o(ready_o), .row_o(row_o),
      .row_idx_o(row_idx_o), .last_o(last_o), .valid_o(valid_o),
      .ready_i(ready_i), .sat_cnt_o(sat_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference requantisation: floor((x + 2^(s-1)) / 2^s), then clamp to int8.
   function automatic longint model_rq(input longint x, input int sh, output bit sat);
      int     s;
      longint y;
      s = (sh > 31) ? 31 : sh;
      if (s == 0) y = x;
      else        y = (x + (longint'(1) << (s - 1))) >>> s;
      sat = 1'b0;
      if (y > 127)       begin y = 127;  sat = 1'b1; end
      else if (y < -128) begin y = -128; sat = 1'b1; end
      return y;
   endfunction

   function automatic tile_t mk_tile(input int a, input int b, input int c, input int d, input int sh);
      tile_t t;
      t.e[0][0] = 32'(a);
      t.e[0][1] = 32'(b);
      t.e[1][0] = 32'(c);
      t.e[1][1] = 32'(d);
      t.sh      = 5'(sh);
      return t;
   endfunction

   function automatic tile_t rand_tile();
      tile_t t;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            case ($urandom_range(0, 2))
               0:       t.e[i][j] = 32'($urandom_range(0, 400)) - 32'd200;
               1:       t.e[i][j] = 32'($urandom_range(0, 80000)) - 32'd40000;
               default: t.e[i][j] = 32'($urandom());
            endcase
         end
      end
      t.sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      return t;
   endfunction

   // One clock: drive at negedge, compare against the model, advance the model.
   task automatic step(input bit rst, input bit vin, input tile_t t, input bit rdy);
      bit          exp_ready, exp_valid, sat;
      logic [15:0] exp_row;
      int          nsat;
      longint      y;
      @(negedge clk_i);
      rst_i   = rst;
      valid_i = vin;
      ready_i = rdy;
      shift_i = t.sh;
      D_i     = t.e;
      #1;
      exp_ready = !rst && (mq.size() < DEPTH);
      exp_valid = !rst && (mq.size() > 0);
      check_value("ready_o", 64'(ready_o), 64'(exp_ready));
      check_value("valid_o", 64'(valid_o), 64'(exp_valid));
      check_value("last_o", 64'(last_o), 64'(exp_valid && mr == 1));
      check_value("sat_cnt_o", 64'(sat_cnt_o), 64'(msat));
      nsat = 0;
      exp_row = 16'h0000;
      if (exp_valid) begin
         for (int j = 0; j < 2; j++) begin
            y = model_rq(longint'($signed(mq[0].e[mr][j])), int'(mq[0].sh), sat);
            exp_row[j*8 +: 8] = y[7:0];
            nsat += int'(sat);
         end
      end
      if (rst || exp_valid) begin
         check_value("row_o", 64'(row_o), 64'(exp_row));
         check_value("row_idx_o", 64'(row_idx_o), 64'(rst ? 0 : mr));
      end
      if (rst) begin
         mq.delete();
         mr   = 0;
         msat = 0;
      end else begin
         if (exp_valid && rdy) begin
            msat = (msat + nsat > 65535) ? 65535 : msat + nsat;
            if (mr == 1) begin
               mr = 0;
               void'(mq.pop_front());
            end else begin
               mr++;
            end
         end
         if (vin && exp_ready) mq.push_back(t);
      end
      @(posedge clk_i);
   endtask

   tile_t tz, ta, tb, tc;

   initial begin
      tz      = mk_tile(0, 0, 0, 0, 0);
      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      D_i     = tz.e;
      shift_i = 5'd0;
      @(posedge clk_i);

      // 1. reset behaviour
      step(1'b1, 1'b0, tz, 1'b0);
      step(1'b1, 1'b0, tz, 1'b0);
      #1;
      check_value("rst_ready", 64'(ready_o), 64'd0);
      check_value("rst_sat", 64'(sat_cnt_o), 64'd0);
      step(1'b0, 1'b0, tz, 1'b1);
      check_value("ready_after_rst", 64'(ready_o), 64'd1);

      // 2. pass-through with shift 0, one-cycle latency
      ta = mk_tile(7, 7, 7, 7, 0);
      step(1'b0, 1'b1, ta, 1'b1);
      #1;
      check_value("t2_latency", 64'(valid_o), 64'd1);
      check_value("t2_row0", 64'(row_o), 64'h0707);
      check_value("t2_last0", 64'(last_o), 64'd0);
      step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t2_idx1", 64'(row_idx_o), 64'd1);
      check_value("t2_last1", 64'(last_o), 64'd1);
      step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t2_drained", 64'(valid_o), 64'd0);

      // 3. rounding with shift 2
      ta = mk_tile(6, -6, 5, -5, 2);
      step(1'b0, 1'b1, ta, 1'b1);
      #1;
      check_value("t3_row0", 64'(row_o), 64'hFF02);
      step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t3_row1", 64'(row_o), 64'hFF01);
      step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t3_sat", 64'(sat_cnt_o), 64'd0);

      // 4. saturation
      ta = mk_tile(300, -300, 127, -128, 0);
      step(1'b0, 1'b1, ta, 1'b1);
      #1;
      check_value("t4_row0", 64'(row_o), 64'h807F);
      step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t4_row1", 64'(row_o), 64'h807F);
      step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t4_sat", 64'(sat_cnt_o), 64'd2);

      // 5. back-pressure: full buffer, held input, ordered drain
      ta = mk_tile(1, 2, 3, 4, 0);
      tb = mk_tile(11, 12, 13, 14, 0);
      tc = mk_tile(21, 22, 23, 24, 0);
      step(1'b0, 1'b1, ta, 1'b0);
      step(1'b0, 1'b1, tb, 1'b0);
      #1;
      check_value("t5_full", 64'(ready_o), 64'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, tc, 1'b0);
      #1;
      check_value("t5_stall_row", 64'(row_o), 64'h0201);
      step(1'b0, 1'b1, tc, 1'b1);
      #1;
      check_value("t5_still_full", 64'(ready_o), 64'd0);
      step(1'b0, 1'b1, tc, 1'b1);
      #1;
      check_value("t5_ready_back", 64'(ready_o), 64'd1);
      step(1'b0, 1'b1, tc, 1'b1);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t5_drained", 64'(valid_o), 64'd0);

      // 6. reset mid-stream
      step(1'b0, 1'b1, ta, 1'b0);
      step(1'b0, 1'b1, tb, 1'b0);
      step(1'b0, 1'b0, tz, 1'b1);
      step(1'b1, 1'b0, tz, 1'b1);
      step(1'b0, 1'b0, tz, 1'b1);
      #1;
      check_value("t6_valid", 64'(valid_o), 64'd0);
      check_value("t6_sat", 64'(sat_cnt_o), 64'd0);
      step(1'b0, 1'b1, tc, 1'b1);
      #1;
      check_value("t6_new_valid", 64'(valid_o), 64'd1);
      check_value("t6_new_idx", 64'(row_idx_o), 64'd0);
      check_value("t6_new_row", 64'(row_o), 64'h1615);

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         ta = rand_tile();
         step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, ta, $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
